// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, instruction/PC widths,
// the halt encoding and the buffered fetch entry.
package fetch_pkg;

  localparam int INSTR_W = 9;
  localparam int PC_W    = 32;
  localparam logic [INSTR_W-1:0] HALT_OP = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {instr, pc} entries with push, pop and a
// synchronous flush; the head is read combinationally from storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_s    = (count_q == CNT_W'(DEPTH));
  assign valid_o   = (count_q != '0);
  // A push into a full buffer is accepted only when the head leaves in the same cycle.
  assign push_ok_s = push_i & (~full_s | pop_i);
  assign pop_ok_s  = pop_i & valid_o;
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues reads at pc_in, buffers responses for decode, flushes on
// redirect and stops on HALT_OP. FETCH_PERF_CNT_EN adds the stall_cycles counter.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               should_run_processor,
  input  logic [PC_W-1:0]    pc_in,
  output logic               pc_advance,
  input  logic               redirect,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc,
  output logic               done,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        stall_cycles,
`endif
  output logic               pc_oob
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic             inflight_q, inflight_d;
  logic [PC_W-1:0]  tag_q, tag_d;
  logic             done_q, done_d;
  logic             oob_q, oob_d;

  logic             fetching_s;
  logic             fifo_valid_s;
  logic             pop_s;
  logic             push_s;
  logic             flush_s;
  logic             halt_pop_s;
  logic             issue_s;
  logic             credit_ok_s;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W:0]   used_s;
  logic [CNT_W:0]   limit_s;
  fetch_entry_t     head_s;
  fetch_entry_t     push_data_s;

  assign fetching_s  = should_run_processor & (state_q == FETCH);
  assign instr_valid = fetching_s & fifo_valid_s;
  assign pop_s       = instr_valid & instr_ready;
  assign halt_pop_s  = pop_s & (head_s.instr == HALT_OP);

  // Slot freed by this cycle's pop counts as credit, so streaming runs at one per cycle.
  assign used_s      = {1'b0, count_s} + (CNT_W+1)'(inflight_q);
  assign limit_s     = (CNT_W+1)'(DEPTH) + (CNT_W+1)'(pop_s);
  assign credit_ok_s = (used_s < limit_s);

  assign issue_s     = fetching_s & ~redirect & ~halt_pop_s & credit_ok_s;
  assign push_s      = fetching_s & inflight_q & ~redirect & ~halt_pop_s;
  assign flush_s     = ~should_run_processor | redirect | halt_pop_s;

  assign pc_advance  = issue_s;
  assign imem_rd_en  = issue_s;
  assign imem_addr   = pc_in[ADDR_W-1:0];
  assign push_data_s = '{instr: imem_rdata, pc: tag_q};
  assign instr_out   = head_s.instr;
  assign instr_pc    = head_s.pc;
  assign done        = done_q;
  assign pc_oob      = oob_q;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .flush_i     (flush_s),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .valid_o     (fifo_valid_s),
    .count_o     (count_s)
  );

  // Next state, in-flight tag, done and out-of-range flag.
  always_comb begin
    state_d    = state_q;
    inflight_d = issue_s;
    tag_d      = tag_q;
    done_d     = done_q;
    oob_d      = oob_q;
    case (state_q)
      IDLE: begin
        if (should_run_processor) state_d = FETCH;
        else                      state_d = IDLE;
      end
      FETCH: begin
        if (!should_run_processor) state_d = IDLE;
        else if (halt_pop_s)       state_d = HALTED;
        else                       state_d = FETCH;
      end
      HALTED: begin
        if (!should_run_processor) state_d = IDLE;
        else                       state_d = HALTED;
      end
      default: state_d = IDLE;
    endcase
    if (issue_s) tag_d = pc_in;
    else         tag_d = tag_q;
    if (!should_run_processor) done_d = 1'b0;
    else if (halt_pop_s)       done_d = 1'b1;
    else                       done_d = done_q;
    if (issue_s && (pc_in[PC_W-1:ADDR_W] != '0)) oob_d = 1'b1;
    else                                          oob_d = oob_q;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      done_q     <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      done_q     <= done_d;
      oob_q      <= oob_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of FETCH cycles in which the PC was held.
  always_comb begin
    stall_d = stall_q;
    if (!should_run_processor) begin
      stall_d = 32'd0;
    end else if ((state_q == FETCH) && !issue_s && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= 32'd0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, backpressure, redirect, halt,
// out-of-range PC and asynchronous reset, against hand-computed expectations.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        run;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        redirect;
  logic        imem_rd_en;
  logic [9:0]  imem_addr;
  logic [8:0]  imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [8:0]  instr_out;
  logic [31:0] instr_pc;
  logic        done;
  logic        pc_oob;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  logic [8:0]  mem [1024];
  int          checks;
  int          errors;
  logic        adv_s;

  instr_fetch_unit dut (
    .clk                  (clk),
    .reset                (reset),
    .should_run_processor (run),
    .pc_in                (pc_in),
    .pc_advance           (pc_advance),
    .redirect             (redirect),
    .imem_rd_en           (imem_rd_en),
    .imem_addr            (imem_addr),
    .imem_rdata           (imem_rdata),
    .instr_valid          (instr_valid),
    .instr_ready          (instr_ready),
    .instr_out            (instr_out),
    .instr_pc             (instr_pc),
    .done                 (done),
`ifdef FETCH_PERF_CNT_EN
    .stall_cycles         (stall_cycles),
`endif
    .pc_oob               (pc_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: PC steps at the edge if pc_advance was high before it.
  task automatic tick();
    adv_s = pc_advance;
    @(posedge clk);
    #1;
    if (adv_s === 1'b1) pc_in = pc_in + 32'd1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_out"},   {23'd0, instr_out},   32'd0);
    chk({tag, "_pc"},    instr_pc,             32'd0);
    chk({tag, "_adv"},   {31'd0, pc_advance},  32'd0);
    chk({tag, "_rden"},  {31'd0, imem_rd_en},  32'd0);
    chk({tag, "_done"},  {31'd0, done},        32'd0);
    chk({tag, "_oob"},   {31'd0, pc_oob},      32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = {1'b0, 8'(i)};
    mem[0]  = 9'h011;
    mem[1]  = 9'h022;
    mem[2]  = 9'h033;
    mem[3]  = 9'h044;
    mem[4]  = 9'h1FF;
    mem[16] = 9'h0AA;
    imem_rdata  = 9'h000;
    reset       = 1'b0;
    run         = 1'b0;
    pc_in       = 32'd0;
    redirect    = 1'b0;
    instr_ready = 1'b0;

    tick(); tick(); #1;
    chk_reset_outputs("rst");

    // Streaming with decode always ready
    tick(); reset = 1'b1; run = 1'b1; instr_ready = 1'b1; pc_in = 32'd0; #1;
    chk("s_idle_adv", {31'd0, pc_advance}, 32'd0);
    tick(); #1;
    chk("s1_adv", {31'd0, pc_advance}, 32'd1);
    chk("s1_addr", {22'd0, imem_addr}, 32'd0);
    chk("s1_valid", {31'd0, instr_valid}, 32'd0);
    tick(); #1;
    chk("s2_adv", {31'd0, pc_advance}, 32'd1);
    tick(); #1;
    chk("s3_valid", {31'd0, instr_valid}, 32'd1);
    chk("s3_out", {23'd0, instr_out}, 32'h011);
    chk("s3_pc", instr_pc, 32'd0);
    chk("s3_adv", {31'd0, pc_advance}, 32'd1);
    tick(); #1;
    chk("s4_out", {23'd0, instr_out}, 32'h022);
    chk("s4_pc", instr_pc, 32'd1);
    chk("s4_adv", {31'd0, pc_advance}, 32'd1);

    // Restart, then backpressure for five FETCH cycles
    tick(); run = 1'b0; pc_in = 32'd0; #1;
    chk("stop_adv", {31'd0, pc_advance}, 32'd0);
    tick(); run = 1'b1; instr_ready = 1'b0; #1;
    chk("bp_idle_valid", {31'd0, instr_valid}, 32'd0);
    tick(); #1;
    chk("bp1_adv", {31'd0, pc_advance}, 32'd1);
    tick(); #1;
    chk("bp2_adv", {31'd0, pc_advance}, 32'd1);
    tick(); #1;
    chk("bp3_adv", {31'd0, pc_advance}, 32'd0);
    chk("bp3_out", {23'd0, instr_out}, 32'h011);
    tick(); #1;
    tick(); #1;
    chk("bp5_adv", {31'd0, pc_advance}, 32'd0);
    chk("bp5_valid", {31'd0, instr_valid}, 32'd1);
    chk("bp5_pc", instr_pc, 32'd0);
    tick(); instr_ready = 1'b1; #1;
`ifdef FETCH_PERF_CNT_EN
    chk("bp_stall_cnt", stall_cycles, 32'd3);
`endif
    chk("rs1_out", {23'd0, instr_out}, 32'h011);
    chk("rs1_adv", {31'd0, pc_advance}, 32'd1);
    tick(); #1;
    chk("rs2_out", {23'd0, instr_out}, 32'h022);
    chk("rs2_pc", instr_pc, 32'd1);

    // Redirect with one buffered entry and one fetch in flight
    tick(); redirect = 1'b1; pc_in = 32'h10; #1;
    chk("rd_head_pc", instr_pc, 32'd2);
    chk("rd_adv", {31'd0, pc_advance}, 32'd0);
    chk("rd_rden", {31'd0, imem_rd_en}, 32'd0);
    tick(); redirect = 1'b0; #1;
    chk("rd1_valid", {31'd0, instr_valid}, 32'd0);
    chk("rd1_adv", {31'd0, pc_advance}, 32'd1);
    chk("rd1_addr", {22'd0, imem_addr}, 32'h10);
    tick(); #1;
    chk("rd2_valid", {31'd0, instr_valid}, 32'd0);
    tick(); #1;
    chk("rd3_valid", {31'd0, instr_valid}, 32'd1);
    chk("rd3_pc", instr_pc, 32'h10);
    chk("rd3_out", {23'd0, instr_out}, 32'h0AA);

    // Halt at pc 4
    tick(); run = 1'b0; pc_in = 32'd0; #1;
    tick(); run = 1'b1; #1;
    for (int i = 0; i < 7; i++) begin
      tick(); #1;
    end
    chk("h_out", {23'd0, instr_out}, 32'h1FF);
    chk("h_pc", instr_pc, 32'd4);
    chk("h_done_pre", {31'd0, done}, 32'd0);
    tick(); #1;
    chk("h1_done", {31'd0, done}, 32'd1);
    chk("h1_adv", {31'd0, pc_advance}, 32'd0);
    chk("h1_rden", {31'd0, imem_rd_en}, 32'd0);
    chk("h1_valid", {31'd0, instr_valid}, 32'd0);
    tick(); #1;
    chk("h2_done", {31'd0, done}, 32'd1);
    chk("h2_rden", {31'd0, imem_rd_en}, 32'd0);
    tick(); run = 1'b0; #1;
    tick(); #1;
    chk("h_stop_done", {31'd0, done}, 32'd0);
    chk("h_stop_adv", {31'd0, pc_advance}, 32'd0);

    // Out-of-range PC
    tick(); run = 1'b1; pc_in = 32'h0000_0400; #1;
    chk("oob0", {31'd0, pc_oob}, 32'd0);
    tick(); #1;
    chk("oob_adv", {31'd0, pc_advance}, 32'd1);
    chk("oob_addr", {22'd0, imem_addr}, 32'd0);
    tick(); #1;
    chk("oob_set", {31'd0, pc_oob}, 32'd1);
    tick(); run = 1'b0; #1;
    tick(); #1;
    chk("oob_sticky", {31'd0, pc_oob}, 32'd1);

    // Asynchronous reset with a full buffer
    tick(); run = 1'b1; pc_in = 32'd0; instr_ready = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
    end
    chk("full_valid", {31'd0, instr_valid}, 32'd1);
    chk("full_adv", {31'd0, pc_advance}, 32'd0);
    #2; reset = 1'b0; #1;
    chk_reset_outputs("arst");
    tick(); reset = 1'b1; pc_in = 32'd0; #1;
    chk("post_rst_idle", {31'd0, pc_advance}, 32'd0);
    tick(); #1;
    chk("post_rst_issue", {31'd0, pc_advance}, 32'd1);
    chk("post_rst_addr", {22'd0, imem_addr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
